// File: rtl/alu_frame_engine.sv
// Framed command engine: pulls a checksummed SOF/OPC/A/B/CKS frame from the RX FIFO,
// drives the ALU, and streams result bytes plus a status byte into the TX FIFO.
module alu_frame_engine #(
    parameter int unsigned NB_DATA        = 16,
    parameter int unsigned NB_OPCODE      = 6,
    parameter logic [7:0]  SOF            = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_fifo_rx_empty,
    input  logic [7:0]           i_data_to_read,
    output logic                 o_fifo_rx_read,
    input  logic                 i_fifo_tx_full,
    output logic                 o_fifo_tx_write,
    output logic [7:0]           o_data_to_write,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_alu_zero,
    input  logic                 i_alu_overflow,
    output logic                 o_busy,
    output logic                 o_frame_err
);

    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_OPC, ST_OPA, ST_OPB, ST_CHECK,
        ST_EXEC, ST_SEND_RES, ST_SEND_STAT, ST_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [NB_IDX-1:0]      idx_q, idx_d;
    logic [NB_TIMEOUT-1:0]  tmo_q, tmo_d;
    logic [NB_OPCODE-1:0]   sh_opc_q, sh_opc_d;
    logic [NB_DATA-1:0]     sh_a_q, sh_a_d;
    logic [NB_DATA-1:0]     sh_b_q, sh_b_d;
    logic [7:0]             cks_q, cks_d;
    logic [NB_OPCODE-1:0]   opc_q, opc_d;
    logic [NB_DATA-1:0]     op_a_q, op_a_d;
    logic [NB_DATA-1:0]     op_b_q, op_b_d;
    logic [NB_DATA-1:0]     res_q, res_d;
    logic [7:0]             stat_q, stat_d;
    logic                   err_q, err_d;

    logic                   recv, timed, send, rd, wr, last_idx;
    logic [7:0]             tx_byte;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            sh_opc_q <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cks_q    <= '0;
            opc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            stat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            sh_opc_q <= sh_opc_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cks_q    <= cks_d;
            opc_q    <= opc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            stat_q   <= stat_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sh_opc_d = sh_opc_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cks_d    = cks_q;
        opc_d    = opc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        stat_d   = stat_q;
        err_d    = 1'b0;
        tx_byte  = 8'h00;

        recv     = (state_q == ST_IDLE) || (state_q == ST_OPC) || (state_q == ST_OPA) ||
                   (state_q == ST_OPB)  || (state_q == ST_CHECK);
        timed    = recv && (state_q != ST_IDLE);
        send     = (state_q == ST_SEND_RES) || (state_q == ST_SEND_STAT) || (state_q == ST_ERR);
        rd       = recv && !i_fifo_rx_empty && !i_reset;
        wr       = send && !i_fifo_tx_full;
        last_idx = (idx_q == NB_IDX'(NB_BYTES - 1));
        tmo_d    = (timed && !rd) ? tmo_q + NB_TIMEOUT'(1) : '0;

        case (state_q)
            ST_IDLE: begin
                if (rd && (i_data_to_read == SOF)) state_d = ST_OPC;
            end
            ST_OPC: begin
                if (rd) begin
                    sh_opc_d = i_data_to_read[NB_OPCODE-1:0];
                    cks_d    = i_data_to_read;
                    idx_d    = '0;
                    state_d  = ST_OPA;
                end
            end
            // Little-endian: each new byte enters at the top and shifts down.
            ST_OPA: begin
                if (rd) begin
                    sh_a_d = (sh_a_q >> 8) | (NB_DATA'(i_data_to_read) << (NB_DATA - 8));
                    cks_d  = cks_q ^ i_data_to_read;
                    idx_d  = last_idx ? '0 : idx_q + NB_IDX'(1);
                    if (last_idx) state_d = ST_OPB;
                end
            end
            ST_OPB: begin
                if (rd) begin
                    sh_b_d = (sh_b_q >> 8) | (NB_DATA'(i_data_to_read) << (NB_DATA - 8));
                    cks_d  = cks_q ^ i_data_to_read;
                    idx_d  = last_idx ? '0 : idx_q + NB_IDX'(1);
                    if (last_idx) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rd) begin
                    if (i_data_to_read == cks_q) begin
                        opc_d   = sh_opc_q;
                        op_a_d  = sh_a_q;
                        op_b_d  = sh_b_q;
                        state_d = ST_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                res_d   = i_alu_result;
                stat_d  = {6'b0, i_alu_overflow, i_alu_zero};
                idx_d   = '0;
                state_d = ST_SEND_RES;
            end
            ST_SEND_RES: begin
                tx_byte = res_q[7:0];
                if (wr) begin
                    res_d = res_q >> 8;
                    idx_d = last_idx ? '0 : idx_q + NB_IDX'(1);
                    if (last_idx) state_d = ST_SEND_STAT;
                end
            end
            ST_SEND_STAT: begin
                tx_byte = stat_q;
                if (wr) state_d = ST_IDLE;
            end
            ST_ERR: begin
                tx_byte = 8'h80;
                if (wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timeout drops the partial frame silently apart from the error pulse.
        if (timed && !rd && (tmo_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1))) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    assign o_fifo_rx_read  = rd;
    assign o_fifo_tx_write = wr;
    assign o_data_to_write = tx_byte;
    assign o_alu_opcode    = opc_q;
    assign o_alu_op_A      = op_a_q;
    assign o_alu_op_B      = op_b_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_frame_err     = err_q;

endmodule
